// File: rtl/xadac_obi_pkg.sv
// Shared OBI types for the xadac unit cluster and its memory arbiter.
// Holds the address/data/ID typedefs and the ID remap table entry.
package xadac_obi_pkg;

  localparam int ObiNoMst     = 2;
  localparam int ObiAddrWidth = 32;
  localparam int ObiDataWidth = 128;
  localparam int ObiBeWidth   = ObiDataWidth / 8;
  localparam int ObiIdWidth   = 2;
  localparam int ObiNoIds     = 2 ** ObiIdWidth;
  localparam int ObiMstWidth  =
    (ObiNoMst > 1) ? $clog2(ObiNoMst) : 1;

  typedef logic [ObiAddrWidth-1:0] AddrT;
  typedef logic [ObiBeWidth-1:0]   BeT;
  typedef logic [ObiDataWidth-1:0] DataT;
  typedef logic [ObiIdWidth-1:0]   IdT;
  typedef logic [ObiMstWidth-1:0]  MstT;

  typedef struct packed {
    logic valid;
    MstT  mst;
    IdT   sid;
  } tbl_entry_t;

endpackage

// File: rtl/xadac_obi_arb_if.sv
// Bus bundle around the xadac OBI arbiter: upstream s_* per unit,
// downstream m_* to the core data port. slave = arbiter view.
interface xadac_obi_arb_if #(
  parameter int NoMst     = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 128,
  parameter int BeWidth   = DataWidth / 8,
  parameter int IdWidth   = 2
);

  logic [NoMst-1:0]           s_req;
  logic [NoMst-1:0]           s_gnt;
  logic [NoMst-1:0]           s_we;
  logic [NoMst*AddrWidth-1:0] s_addr;
  logic [NoMst*BeWidth-1:0]   s_be;
  logic [NoMst*DataWidth-1:0] s_wdata;
  logic [NoMst*IdWidth-1:0]   s_aid;
  logic [NoMst-1:0]           s_rvalid;
  logic [NoMst-1:0]           s_rready;
  logic [IdWidth-1:0]         s_rid;
  logic [DataWidth-1:0]       s_rdata;

  logic                       m_req;
  logic                       m_gnt;
  logic                       m_we;
  logic [AddrWidth-1:0]       m_addr;
  logic [BeWidth-1:0]         m_be;
  logic [DataWidth-1:0]       m_wdata;
  logic [IdWidth-1:0]         m_aid;
  logic                       m_rvalid;
  logic                       m_rready;
  logic [IdWidth-1:0]         m_rid;
  logic [DataWidth-1:0]       m_rdata;

  modport slave (
    input  s_req, s_we, s_addr, s_be,
    input  s_wdata, s_aid, s_rready,
    output s_gnt, s_rvalid, s_rid, s_rdata,
    output m_req, m_we, m_addr, m_be,
    output m_wdata, m_aid, m_rready,
    input  m_gnt, m_rvalid, m_rid, m_rdata
  );

  modport master (
    output s_req, s_we, s_addr, s_be,
    output s_wdata, s_aid, s_rready,
    input  s_gnt, s_rvalid, s_rid, s_rdata,
    input  m_req, m_we, m_addr, m_be,
    input  m_wdata, m_aid, m_rready,
    output m_gnt, m_rvalid, m_rid, m_rdata
  );

endinterface

// File: rtl/xadac_rr_arb.sv
// N-way round-robin arbiter: search from ptr upward with wrap.
// Ports: en_i/req_i in, vld_o/idx_o/oh_o winner out.
module xadac_rr_arb #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] oh_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [W-1:0] j;
    j     = '0;
    vld_o = 1'b0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr_q) + k) % N);
      if (en_i && !vld_o && req_i[j]) begin
        vld_o = 1'b1;
        idx_o = j;
      end
    end
  end

  assign oh_o = vld_o ? (N'(1) << idx_o) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (vld_o)
      ptr_d = (int'(idx_o) == N - 1) ? '0
                                     : idx_o + W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xadac_obi_arb.sv
// Shares one OBI port among xadac units; remaps upstream IDs
// through a table. Ports: clk, rstn, bus (slave), err_o sticky.
module xadac_obi_arb
  import xadac_obi_pkg::*;
#(
  parameter int NoMst     = ObiNoMst,
  parameter int AddrWidth = ObiAddrWidth,
  parameter int DataWidth = ObiDataWidth,
  parameter int BeWidth   = DataWidth / 8,
  parameter int IdWidth   = ObiIdWidth
) (
  input  logic            clk,
  input  logic            rstn,
  xadac_obi_arb_if.slave  bus,
  output logic            err_o
);

  localparam int NoIds = 2 ** IdWidth;

  tbl_entry_t [NoIds-1:0] tbl_q, tbl_d;

  logic m_req_q, m_req_d;
  logic m_we_q, m_we_d;
  AddrT m_addr_q, m_addr_d;
  BeT   m_be_q, m_be_d;
  DataT m_wdata_q, m_wdata_d;
  IdT   m_aid_q, m_aid_d;
  logic err_q, err_d;

  logic             load, any_free, win;
  IdT               free_id;
  MstT              win_idx;
  logic [NoMst-1:0] win_oh;
  tbl_entry_t       rsp_e;
  logic             rsp_hit, rready;

  // Lowest free ID from the registered table only, so a
  // release this cycle is not reused until the next.
  always_comb begin
    any_free = 1'b0;
    free_id  = '0;
    for (int i = NoIds - 1; i >= 0; i--) begin
      if (!tbl_q[i].valid) begin
        any_free = 1'b1;
        free_id  = IdT'(i);
      end
    end
  end

  assign load = !m_req_q || bus.m_gnt;

  xadac_rr_arb #(
    .N (NoMst),
    .W (ObiMstWidth)
  ) u_rr (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (load && any_free),
    .req_i (bus.s_req),
    .vld_o (win),
    .idx_o (win_idx),
    .oh_o  (win_oh)
  );

  assign bus.s_gnt = win_oh;

  assign rsp_e   = tbl_q[bus.m_rid];
  assign rsp_hit = bus.m_rvalid && rsp_e.valid;

  // Unallocated IDs are drained so the port never stalls.
  always_comb begin
    bus.s_rvalid = '0;
    rready       = 1'b1;
    if (rsp_hit) begin
      bus.s_rvalid[rsp_e.mst] = 1'b1;
      rready = bus.s_rready[rsp_e.mst];
    end
  end

  assign bus.m_rready = rready;
  assign bus.s_rid    = rsp_hit ? rsp_e.sid : '0;
  assign bus.s_rdata  = bus.m_rdata;

  always_comb begin
    tbl_d = tbl_q;
    if (rsp_hit && rready)
      tbl_d[bus.m_rid].valid = 1'b0;
    if (win)
      tbl_d[free_id] = '{
        valid: 1'b1,
        mst:   win_idx,
        sid:   bus.s_aid[win_idx*IdWidth +: IdWidth]
      };
  end

  always_comb begin
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_be_d    = m_be_q;
    m_wdata_d = m_wdata_q;
    m_aid_d   = m_aid_q;
    if (load) begin
      m_req_d = win;
      if (win) begin
        m_we_d    = bus.s_we[win_idx];
        m_addr_d  =
          bus.s_addr[win_idx*AddrWidth +: AddrWidth];
        m_be_d    = bus.s_be[win_idx*BeWidth +: BeWidth];
        m_wdata_d =
          bus.s_wdata[win_idx*DataWidth +: DataWidth];
        m_aid_d   = free_id;
      end
    end
  end

  assign err_d = err_q || (bus.m_rvalid && !rsp_e.valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tbl_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_be_q    <= '0;
      m_wdata_q <= '0;
      m_aid_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      tbl_q     <= tbl_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
      m_aid_q   <= m_aid_d;
      err_q     <= err_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_be    = m_be_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_aid   = m_aid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_xadac_obi_arb.sv
// Directed bench for xadac_obi_arb: grants, ID remap, table full,
// backpressure, stray responses and mid-operation reset.
module tb_xadac_obi_arb;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic err;
  int   n_chk = 0;
  int   n_err = 0;

  xadac_obi_arb_if bus ();

  xadac_obi_arb dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus.slave),
    .err_o (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.s_req    = '0;
    bus.s_we     = '0;
    bus.s_addr   = '0;
    bus.s_be     = '0;
    bus.s_wdata  = '0;
    bus.s_aid    = '0;
    bus.s_rready = '1;
    bus.m_gnt    = 1'b1;
    bus.m_rvalid = 1'b0;
    bus.m_rid    = '0;
    bus.m_rdata  = '0;
  endtask

  task automatic do_rst();
    rstn = 1'b0;
    idle();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic set_m(input int i, input logic we,
                       input logic [31:0] a,
                       input logic [1:0] id);
    bus.s_we[i]             = we;
    bus.s_addr[i*32 +: 32]  = a;
    bus.s_aid[i*2 +: 2]     = id;
    bus.s_be[i*16 +: 16]    = '1;
    bus.s_wdata[i*128 +: 128] = {4{a}};
  endtask

  task automatic rsp(input logic [1:0] id,
                     input logic [127:0] d);
    bus.m_rvalid = 1'b1;
    bus.m_rid    = id;
    bus.m_rdata  = d;
  endtask

  initial begin
    idle();
    step();
    step();
    chk("rst_mreq", bus.m_req, 0);
    chk("rst_maid", bus.m_aid, 0);
    chk("rst_maddr", bus.m_addr, 0);
    chk("rst_mwe", bus.m_we, 0);
    chk("rst_err", err, 0);
    chk("rst_gnt", bus.s_gnt, 0);
    rstn = 1'b1;

    // single master write
    set_m(0, 1'b1, 32'h1000, 2'd3);
    bus.s_req = 2'b01;
    settle();
    chk("t1_gnt", bus.s_gnt, 2'b01);
    step();
    bus.s_req = '0;
    settle();
    chk("t1_mreq", bus.m_req, 1);
    chk("t1_maid", bus.m_aid, 0);
    chk("t1_maddr", bus.m_addr, 32'h1000);
    chk("t1_mwe", bus.m_we, 1);
    chk("t1_mbe", bus.m_be, 16'hffff);
    chk("t1_mwdata", bus.m_wdata, {4{32'h1000}});
    step();
    chk("t1_mreq_drop", bus.m_req, 0);
    rsp(2'd0, 128'hdead_beef);
    settle();
    chk("t1_rvalid", bus.s_rvalid, 2'b01);
    chk("t1_rid", bus.s_rid, 3);
    chk("t1_rdata", bus.s_rdata, 128'hdead_beef);
    chk("t1_rready", bus.m_rready, 1);
    step();
    bus.m_rvalid = 1'b0;
    set_m(1, 1'b0, 32'h2000, 2'd1);
    bus.s_req = 2'b10;
    settle();
    chk("t1_gnt1", bus.s_gnt, 2'b10);
    step();
    bus.s_req = '0;
    settle();
    chk("t1_freed_aid", bus.m_aid, 0);
    chk("t1_addr1", bus.m_addr, 32'h2000);
    chk("t1_we1", bus.m_we, 0);

    // contention, then table full
    do_rst();
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1'b1, 32'h100 + k, 2'(k));
      set_m(1, 1'b0, 32'h200 + k, 2'(k));
      bus.s_req = 2'b11;
      settle();
      chk("t2_gnt", bus.s_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("t2_maid", bus.m_aid, k);
      chk("t2_maddr", bus.m_addr,
          (k % 2 == 0) ? 32'h100 + k : 32'h200 + k);
    end
    settle();
    chk("t3_full_gnt", bus.s_gnt, 0);
    step();
    chk("t3_full_mreq", bus.m_req, 0);
    set_m(0, 1'b1, 32'h300, 2'd1);
    set_m(1, 1'b0, 32'h400, 2'd3);
    rsp(2'd2, 128'h22);
    settle();
    chk("t3_rel_gnt", bus.s_gnt, 0);
    chk("t3_rel_rvalid", bus.s_rvalid, 2'b01);
    chk("t3_rel_rid", bus.s_rid, 2);
    step();
    bus.m_rvalid = 1'b0;
    settle();
    chk("t3_regnt", bus.s_gnt, 2'b01);
    step();
    bus.s_req = '0;
    settle();
    chk("t3_realloc", bus.m_aid, 2);
    chk("t3_realloc_addr", bus.m_addr, 32'h300);

    // out-of-order responses
    rsp(2'd3, 128'h33);
    settle();
    chk("t2_r3_valid", bus.s_rvalid, 2'b10);
    chk("t2_r3_rid", bus.s_rid, 3);
    step();
    rsp(2'd0, 128'h0);
    settle();
    chk("t2_r0_valid", bus.s_rvalid, 2'b01);
    chk("t2_r0_rid", bus.s_rid, 0);
    step();
    rsp(2'd2, 128'h2);
    settle();
    chk("t2_r2_valid", bus.s_rvalid, 2'b01);
    chk("t2_r2_rid", bus.s_rid, 1);
    step();

    // R backpressure on master 1
    bus.s_rready = 2'b01;
    rsp(2'd1, 128'h11);
    settle();
    chk("t4_r_valid", bus.s_rvalid, 2'b10);
    chk("t4_r_rid", bus.s_rid, 1);
    chk("t4_r_rready", bus.m_rready, 0);
    step();
    chk("t4_r_hold", bus.s_rvalid, 2'b10);
    bus.s_rready = 2'b11;
    settle();
    chk("t4_r_go", bus.m_rready, 1);
    step();
    bus.m_rvalid = 1'b0;
    chk("t4_noerr", err, 0);

    // stray response
    rsp(2'd1, 128'h55);
    settle();
    chk("t5_rvalid", bus.s_rvalid, 0);
    chk("t5_rready", bus.m_rready, 1);
    step();
    bus.m_rvalid = 1'b0;
    settle();
    chk("t5_err", err, 1);
    step();
    chk("t5_err_sticky", err, 1);

    // A-channel backpressure
    do_rst();
    chk("t4_err_clr", err, 0);
    bus.m_gnt = 1'b0;
    set_m(0, 1'b1, 32'hA0, 2'd0);
    bus.s_req = 2'b01;
    settle();
    chk("t4_gnt0", bus.s_gnt, 2'b01);
    step();
    set_m(0, 1'b1, 32'hB0, 2'd1);
    set_m(1, 1'b0, 32'hC0, 2'd2);
    bus.s_req = 2'b11;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t4_stall_gnt", bus.s_gnt, 0);
      chk("t4_stall_req", bus.m_req, 1);
      chk("t4_stall_addr", bus.m_addr, 32'hA0);
      step();
    end
    bus.m_gnt = 1'b1;
    settle();
    chk("t4_resume_gnt", bus.s_gnt, 2'b10);
    step();
    bus.s_req = '0;
    settle();
    chk("t4_resume_addr", bus.m_addr, 32'hC0);
    chk("t4_resume_aid", bus.m_aid, 1);

    // reset with outstanding transactions
    do_rst();
    set_m(0, 1'b1, 32'hD0, 2'd2);
    bus.s_req = 2'b01;
    step();
    step();
    step();
    bus.s_req = '0;
    settle();
    chk("t6_pre_aid", bus.m_aid, 2);
    rstn = 1'b0;
    settle();
    chk("t6_rst_mreq", bus.m_req, 0);
    chk("t6_rst_aid", bus.m_aid, 0);
    chk("t6_rst_addr", bus.m_addr, 0);
    chk("t6_rst_gnt", bus.s_gnt, 0);
    chk("t6_rst_err", err, 0);
    step();
    rstn = 1'b1;
    set_m(1, 1'b0, 32'hE0, 2'd3);
    bus.s_req = 2'b10;
    settle();
    chk("t6_fresh_gnt", bus.s_gnt, 2'b10);
    step();
    bus.s_req = '0;
    settle();
    chk("t6_fresh_aid", bus.m_aid, 0);
    chk("t6_fresh_req", bus.m_req, 1);
    rsp(2'd2, 128'h77);
    settle();
    chk("t6_old_rvalid", bus.s_rvalid, 0);
    chk("t6_old_rready", bus.m_rready, 1);
    step();
    bus.m_rvalid = 1'b0;
    chk("t6_old_err", err, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
